ristretto_if_dec_queue: RTL and testbench

RISTRETTO_IF_DEC_QUEUE -- requirements
Module: ristretto_if_dec_queue

---
 rtl/ristretto_if_dec_queue.sv | 132 +++++++++++++
 tb/tb_ristretto_if_dec_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ristretto_if_dec_queue.sv
// Fetch-to-decode instruction queue.
// A circular buffer of Depth entries sits between fetch and decode. Outputs come
// only from registered state, so there is no path from the fetch inputs to the
// decode outputs.
// A flush empties the queue and leaves a single NOP bubble. The bubble carries
// the next-PC value that was present at the flush edge, and decode consumes it
// before any entry pushed after the flush.
//
// Handshake: fetch pushes on fq_valid_i & fq_ready_o; decode pops on
// fq_valid_o & fq_ready_i. Both sides follow valid/ready rules: valid never
// depends on ready, and payload is stable while valid is high and not yet taken.
// fq_stall_i blocks pops. fq_flush_i overrides everything except reset.
module ristretto_if_dec_queue #(
    parameter int                   DataWidth = 32,
    parameter int                   Depth     = 2,
    parameter logic [DataWidth-1:0] NopInstr  = DataWidth'(32'h00000013)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    // fetch side
    input  logic                         fq_valid_i,
    output logic                         fq_ready_o,
    input  logic [DataWidth-1:0]         fq_instr_i,
    input  logic [DataWidth-1:0]         fq_next_pc_i,
    input  logic                         fq_pb_tag_i,
    input  logic [1:0]                   fq_penality_i,
    // decode side
    output logic                         fq_valid_o,
    input  logic                         fq_ready_i,
    output logic [DataWidth-1:0]         fq_instr_o,
    output logic [DataWidth-1:0]         fq_next_pc_o,
    output logic                         fq_pb_tag_o,
    output logic [1:0]                   fq_penality_o,
    // pipeline control
    input  logic                         fq_stall_i,
    input  logic                         fq_flush_i,
    output logic [$clog2(Depth+1)-1:0]   fq_count_o
);

    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

    logic [DataWidth-1:0] r_mem_instr [Depth];
    logic [DataWidth-1:0] r_mem_pc    [Depth];
    logic                 r_mem_tag   [Depth];
    logic [1:0]           r_mem_pen   [Depth];

    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_bubble;
    logic [DataWidth-1:0] r_bubble_pc;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_pop_entry;

    // The ready signal depends only on occupancy. A full queue never accepts a
    // push in the same cycle as a pop.
    assign fq_ready_o  = (r_count < DEPTH_C);
    assign fq_count_o  = r_count;
    assign w_push      = fq_valid_i & fq_ready_o & ~fq_flush_i;
    assign w_pop       = fq_valid_o & fq_ready_i & ~fq_stall_i & ~fq_flush_i;
    // A pending bubble sits ahead of the stored entries, so popping it leaves
    // the buffer untouched.
    assign w_pop_entry = w_pop & ~r_bubble;

    // Entry storage: written at the write pointer on each push; not reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= fq_instr_i;
            r_mem_pc[r_wr_ptr]    <= fq_next_pc_i;
            r_mem_tag[r_wr_ptr]   <= fq_pb_tag_i;
            r_mem_pen[r_wr_ptr]   <= fq_penality_i;
        end
    end

    // Pointer, occupancy and bubble control. Priority: reset, flush, then push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_bubble    <= 1'b0;
            r_bubble_pc <= '0;
        end else if (fq_flush_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_bubble    <= 1'b1;
            r_bubble_pc <= fq_next_pc_i;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_entry) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_pop && r_bubble) begin
                r_bubble <= 1'b0;
            end
            case ({w_push, w_pop_entry})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output selection: a pending bubble is shown first, then the head entry,
    // and an idle pattern when the queue is empty.
    always_comb begin
        fq_valid_o    = 1'b0;
        fq_instr_o    = NopInstr;
        fq_next_pc_o  = '0;
        fq_pb_tag_o   = 1'b0;
        fq_penality_o = 2'b00;
        if (r_bubble) begin
            fq_valid_o    = 1'b1;
            fq_penality_o = 2'b01;
            fq_next_pc_o  = r_bubble_pc;
        end else if (r_count != '0) begin
            fq_valid_o    = 1'b1;
            fq_instr_o    = r_mem_instr[r_rd_ptr];
            fq_next_pc_o  = r_mem_pc[r_rd_ptr];
            fq_pb_tag_o   = r_mem_tag[r_rd_ptr];
            fq_penality_o = r_mem_pen[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_ristretto_if_dec_queue.sv
// Bench for the fetch-to-decode queue with a Depth=2, 32-bit configuration.
// Directed stimulus pushes the expected decode-side entries into exp_q. A
// monitor compares each entry that decode consumes against the head of exp_q.
// The stimulus also checks occupancy, ready and output values directly.
module tb_ristretto_if_dec_queue;

  localparam int DW = 32;
  localparam int EW = 2 * DW + 3;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic          fq_valid_i;
  logic          fq_ready_o;
  logic [DW-1:0] fq_instr_i;
  logic [DW-1:0] fq_next_pc_i;
  logic          fq_pb_tag_i;
  logic [1:0]    fq_penality_i;
  logic          fq_valid_o;
  logic          fq_ready_i;
  logic [DW-1:0] fq_instr_o;
  logic [DW-1:0] fq_next_pc_o;
  logic          fq_pb_tag_o;
  logic [1:0]    fq_penality_o;
  logic          fq_stall_i;
  logic          fq_flush_i;
  logic [1:0]    fq_count_o;

  ristretto_if_dec_queue #(
    .DataWidth (DW),
    .Depth     (2),
    .NopInstr  (32'h00000013)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fq_valid_i    (fq_valid_i),
    .fq_ready_o    (fq_ready_o),
    .fq_instr_i    (fq_instr_i),
    .fq_next_pc_i  (fq_next_pc_i),
    .fq_pb_tag_i   (fq_pb_tag_i),
    .fq_penality_i (fq_penality_i),
    .fq_valid_o    (fq_valid_o),
    .fq_ready_i    (fq_ready_i),
    .fq_instr_o    (fq_instr_o),
    .fq_next_pc_o  (fq_next_pc_o),
    .fq_pb_tag_o   (fq_pb_tag_o),
    .fq_penality_o (fq_penality_o),
    .fq_stall_i    (fq_stall_i),
    .fq_flush_i    (fq_flush_i),
    .fq_count_o    (fq_count_o)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [EW-1:0] mk(input logic [DW-1:0] instr, input logic [DW-1:0] pc,
                                       input logic tag, input logic [1:0] pen);
    return {instr, pc, tag, pen};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a fetch entry; its side fields are derived from the instruction.
  // When accept is set, the entry is also queued as an expected decode output.
  task automatic drive_push(input logic [DW-1:0] instr, input bit accept);
    logic [DW-1:0] v;
    v = instr;
    fq_valid_i    = 1'b1;
    fq_instr_i    = v;
    fq_next_pc_i  = v + 32'h1000;
    fq_pb_tag_i   = v[0];
    fq_penality_i = v[2:1];
    if (accept) exp_q.push_back(mk(v, v + 32'h1000, v[0], v[2:1]));
  endtask

  task automatic idle_fetch();
    fq_valid_i = 1'b0;
  endtask

  // ---------------- monitor ----------------
  // Compare every entry that decode consumes against the head of the expected queue.
  always @(negedge clk_i) begin
    if (!rst_i && fq_valid_o === 1'b1 && fq_ready_i && !fq_stall_i && !fq_flush_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry",
                 {fq_instr_o, fq_next_pc_o, fq_pb_tag_o, fq_penality_o});
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({fq_instr_o, fq_next_pc_o, fq_pb_tag_o, fq_penality_o} !== e) begin
          n_errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h",
                   {fq_instr_o, fq_next_pc_o, fq_pb_tag_o, fq_penality_o}, e);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    n_errors++;
    $display("FAIL timeout: got no end of stimulus expected finish before 50000");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_i         = 1'b1;
    fq_valid_i    = 1'b0;
    fq_instr_i    = '0;
    fq_next_pc_i  = '0;
    fq_pb_tag_i   = 1'b0;
    fq_penality_i = 2'b00;
    fq_ready_i    = 1'b0;
    fq_stall_i    = 1'b0;
    fq_flush_i    = 1'b0;

    // reset values
    #2;
    check("rst_count", EW'(fq_count_o), EW'(0));
    check("rst_valid", EW'(fq_valid_o), EW'(0));
    check("rst_ready", EW'(fq_ready_o), EW'(1));
    check("rst_outs", {fq_instr_o, fq_next_pc_o, fq_pb_tag_o, fq_penality_o},
          mk(32'h13, 32'h0, 1'b0, 2'b00));
    step();
    step();
    rst_i = 1'b0;

    // fill and drain
    drive_push(32'hA, 1'b1);
    step();
    drive_push(32'hB, 1'b1);
    step();
    check("fill_count", EW'(fq_count_o), EW'(2));
    check("fill_ready", EW'(fq_ready_o), EW'(0));
    drive_push(32'hC, 1'b0);
    step();
    idle_fetch();
    check("full_ignore_count", EW'(fq_count_o), EW'(2));
    check("full_head", EW'(fq_instr_o), EW'(32'hA));
    fq_ready_i = 1'b1;
    step();
    check("drain_head_b", EW'(fq_instr_o), EW'(32'hB));
    step();
    check("drain_count", EW'(fq_count_o), EW'(0));
    check("drain_valid", EW'(fq_valid_o), EW'(0));
    check("idle_outs", {fq_instr_o, fq_next_pc_o, fq_pb_tag_o, fq_penality_o},
          mk(32'h13, 32'h0, 1'b0, 2'b00));
    fq_ready_i = 1'b0;

    // stall hold with a concurrent push
    drive_push(32'hA, 1'b1);
    step();
    idle_fetch();
    fq_stall_i = 1'b1;
    fq_ready_i = 1'b1;
    drive_push(32'hB, 1'b1);
    step();
    idle_fetch();
    step();
    step();
    check("stall_instr", EW'(fq_instr_o), EW'(32'hA));
    check("stall_valid", EW'(fq_valid_o), EW'(1));
    check("stall_count", EW'(fq_count_o), EW'(2));
    fq_stall_i = 1'b0;
    step();
    step();
    check("stall_drain_count", EW'(fq_count_o), EW'(0));
    fq_ready_i = 1'b0;

    // flush with a concurrent push
    drive_push(32'hA, 1'b1);
    step();
    drive_push(32'hB, 1'b1);
    step();
    drive_push(32'hC, 1'b0);
    fq_next_pc_i = 32'h100;
    fq_flush_i   = 1'b1;
    exp_q.delete();
    exp_q.push_back(mk(32'h13, 32'h100, 1'b0, 2'b01));
    step();
    fq_flush_i = 1'b0;
    idle_fetch();
    check("flush_count", EW'(fq_count_o), EW'(0));
    check("flush_bubble", {fq_valid_o, fq_instr_o, fq_next_pc_o, fq_pb_tag_o, fq_penality_o},
          EW'({1'b1, mk(32'h13, 32'h100, 1'b0, 2'b01)}));
    fq_ready_i = 1'b1;
    step();
    check("bubble_gone", EW'(fq_valid_o), EW'(0));
    fq_ready_i = 1'b0;

    // pointer wrap: push and pop in the same cycle
    fq_ready_i = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      drive_push(DW'(v), 1'b1);
      step();
      check("wrap_count", EW'(fq_count_o), EW'(1));
    end
    idle_fetch();
    step();
    check("wrap_end_count", EW'(fq_count_o), EW'(0));
    fq_ready_i = 1'b0;

    // flush during stall, then a push queued behind the bubble
    drive_push(32'hA, 1'b1);
    step();
    idle_fetch();
    fq_stall_i   = 1'b1;
    fq_ready_i   = 1'b1;
    fq_flush_i   = 1'b1;
    fq_next_pc_i = 32'h200;
    exp_q.delete();
    exp_q.push_back(mk(32'h13, 32'h200, 1'b0, 2'b01));
    step();
    fq_flush_i = 1'b0;
    check("stflush_count", EW'(fq_count_o), EW'(0));
    check("stflush_bubble", {fq_valid_o, fq_instr_o, fq_next_pc_o, fq_penality_o},
          EW'({1'b1, 32'h13, 32'h200, 2'b01}));
    drive_push(32'hE, 1'b1);
    step();
    idle_fetch();
    step();
    check("bubble_first", EW'(fq_instr_o), EW'(32'h13));
    check("behind_bubble_count", EW'(fq_count_o), EW'(1));
    fq_stall_i = 1'b0;
    step();
    check("after_bubble_head", EW'(fq_instr_o), EW'(32'hE));
    step();
    check("stflush_end_valid", EW'(fq_valid_o), EW'(0));
    fq_ready_i = 1'b0;

    // async reset with two entries and a pending bubble
    fq_flush_i   = 1'b1;
    fq_next_pc_i = 32'h300;
    exp_q.push_back(mk(32'h13, 32'h300, 1'b0, 2'b01));
    step();
    fq_flush_i = 1'b0;
    drive_push(32'hA, 1'b1);
    step();
    drive_push(32'hB, 1'b1);
    step();
    idle_fetch();
    check("pre_rst_count", EW'(fq_count_o), EW'(2));
    #1;
    rst_i = 1'b1;
    #1;
    check("async_rst_count", EW'(fq_count_o), EW'(0));
    check("async_rst_valid", EW'(fq_valid_o), EW'(0));
    check("async_rst_ready", EW'(fq_ready_o), EW'(1));
    exp_q.delete();
    #1;
    rst_i = 1'b0;

    // the first edge after reset accepts a push
    drive_push(32'hD, 1'b1);
    step();
    idle_fetch();
    check("post_rst_count", EW'(fq_count_o), EW'(1));
    fq_ready_i = 1'b1;
    step();
    fq_ready_i = 1'b0;
    check("post_rst_drain", EW'(fq_count_o), EW'(0));

    // final report
    step();
    check("exp_q_empty", EW'(exp_q.size()), EW'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
